// File: rtl/tcp_tx_ctrl.sv
// Transmit-side segment controller: latches the header bundle per request, slices the
// application byte stream into segments with forced tlast, and owns SND.NXT.
module tcp_tx_ctrl #(
  parameter int MSS   = 1460,
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [LEN_W-1:0] i_req_len,
  input  logic [7:0]       i_req_flags,
  input  logic [31:0]      i_rcv_nxt,
  input  logic [15:0]      i_window_size,
  input  logic [15:0]      i_source_port,
  input  logic [15:0]      i_dest_port,
  input  logic [31:0]      i_src_ip,
  input  logic [31:0]      i_dst_ip,
  input  logic             i_seq_load,
  input  logic [31:0]      i_seq_init,
  input  logic [7:0]       s_axis_app_tdata,
  input  logic             s_axis_app_tvalid,
  output logic             s_axis_app_tready,
  output logic [7:0]       m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready,
  output logic             m_axis_data_tlast,
  output logic             m_axis_data_tkeep,
  output logic             o_hdr_valid,
  output logic             o_no_data,
  output logic [15:0]      o_ip_len,
  output logic [31:0]      o_seq_number,
  output logic [31:0]      o_ack_number,
  output logic [7:0]       o_flags,
  output logic [15:0]      o_window_size,
  output logic [15:0]      o_source_port,
  output logic [15:0]      o_dest_port,
  output logic [31:0]      o_src_ip,
  output logic [31:0]      o_dst_ip,
  input  logic             i_packet_done,
  output logic [31:0]      o_snd_nxt,
  output logic             o_err,
  output logic [15:0]      o_seg_count
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] len_in;
  logic             clamp;
  logic             accept;
  logic             hs;
  logic             last_byte;

  // A pending seq load takes priority, so the request is held off for that cycle.
  assign o_req_ready = (state_q == IDLE) && !i_seq_load;
  assign accept      = i_req_valid && o_req_ready;
  assign clamp       = i_req_len > LEN_W'(MSS);
  assign len_in      = clamp ? LEN_W'(MSS) : i_req_len;

  assign last_byte   = (len_q != '0) && (byte_cnt == len_q - LEN_W'(1));
  assign hs          = (state_q == SEND) && s_axis_app_tvalid && m_axis_data_tready;

  assign m_axis_data_tdata  = s_axis_app_tdata;
  assign m_axis_data_tvalid = (state_q == SEND) && s_axis_app_tvalid;
  assign s_axis_app_tready  = (state_q == SEND) && m_axis_data_tready;
  assign m_axis_data_tlast  = (state_q == SEND) && last_byte;
  assign m_axis_data_tkeep  = 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = SEND;
      SEND:      if ((len_q == '0) || (hs && last_byte)) state_d = WAIT_DONE;
      WAIT_DONE: if (i_packet_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      byte_cnt      <= '0;
      o_hdr_valid   <= 1'b0;
      o_no_data     <= 1'b0;
      o_ip_len      <= '0;
      o_seq_number  <= '0;
      o_ack_number  <= '0;
      o_flags       <= '0;
      o_window_size <= '0;
      o_source_port <= '0;
      o_dest_port   <= '0;
      o_src_ip      <= '0;
      o_dst_ip      <= '0;
      o_snd_nxt     <= '0;
      o_err         <= 1'b0;
      o_seg_count   <= '0;
    end else begin
      state_q     <= state_d;
      o_hdr_valid <= (state_d != IDLE);
      o_err       <= accept && clamp;

      if (accept) begin
        len_q         <= len_in;
        byte_cnt      <= '0;
        o_no_data     <= (len_in == '0);
        o_ip_len      <= 16'(len_in) + 16'd40;
        o_seq_number  <= o_snd_nxt;
        o_ack_number  <= i_rcv_nxt;
        o_flags       <= i_req_flags;
        o_window_size <= i_window_size;
        o_source_port <= i_source_port;
        o_dest_port   <= i_dest_port;
        o_src_ip      <= i_src_ip;
        o_dst_ip      <= i_dst_ip;
      end else if (hs) begin
        byte_cnt <= byte_cnt + LEN_W'(1);
      end

      // SYN and FIN each consume one sequence number.
      if ((state_q == IDLE) && i_seq_load) begin
        o_snd_nxt <= i_seq_init;
      end else if ((state_q == WAIT_DONE) && i_packet_done) begin
        o_snd_nxt   <= o_snd_nxt + 32'(len_q) + 32'(o_flags[1]) + 32'(o_flags[0]);
        o_seg_count <= o_seg_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// Scoreboard bench for tcp_tx_ctrl: stimulus queues expected beats, headers and
// post-done state; a negedge monitor pops and compares as the DUT presents them.
module tb_tcp_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_len = '0;
  logic [7:0]  req_flags = '0;
  logic [31:0] rcv_nxt = '0;
  logic [15:0] window_size = '0;
  logic [15:0] source_port = '0;
  logic [15:0] dest_port = '0;
  logic [31:0] src_ip = '0;
  logic [31:0] dst_ip = '0;
  logic        seq_load = 1'b0;
  logic [31:0] seq_init = '0;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tkeep;
  logic        hdr_valid;
  logic        no_data;
  logic [15:0] ip_len;
  logic [31:0] seq_number;
  logic [31:0] ack_number;
  logic [7:0]  flags;
  logic [15:0] win_out;
  logic [15:0] sport_out;
  logic [15:0] dport_out;
  logic [31:0] sip_out;
  logic [31:0] dip_out;
  logic        packet_done = 1'b0;
  logic [31:0] snd_nxt;
  logic        err;
  logic [15:0] seg_count;

  always #5 clk = ~clk;

  tcp_tx_ctrl #(.MSS(1460), .LEN_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_len(req_len), .i_req_flags(req_flags), .i_rcv_nxt(rcv_nxt),
    .i_window_size(window_size), .i_source_port(source_port), .i_dest_port(dest_port),
    .i_src_ip(src_ip), .i_dst_ip(dst_ip),
    .i_seq_load(seq_load), .i_seq_init(seq_init),
    .s_axis_app_tdata(s_tdata), .s_axis_app_tvalid(s_tvalid), .s_axis_app_tready(s_tready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid), .m_axis_data_tready(m_tready),
    .m_axis_data_tlast(m_tlast), .m_axis_data_tkeep(m_tkeep),
    .o_hdr_valid(hdr_valid), .o_no_data(no_data), .o_ip_len(ip_len),
    .o_seq_number(seq_number), .o_ack_number(ack_number), .o_flags(flags),
    .o_window_size(win_out), .o_source_port(sport_out), .o_dest_port(dport_out),
    .o_src_ip(sip_out), .o_dst_ip(dip_out),
    .i_packet_done(packet_done), .o_snd_nxt(snd_nxt), .o_err(err), .o_seg_count(seg_count)
  );

  typedef struct {
    logic [7:0] d;
    logic       last;
  } beat_t;

  typedef struct {
    logic [31:0] seq;
    logic [31:0] ack;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] ip_len;
    logic [15:0] win;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [7:0]  flags;
    logic        nd;
  } hdr_t;

  typedef struct {
    logic [31:0] snd;
    logic [15:0] seg;
  } done_t;

  beat_t      exp_q[$];
  hdr_t       hdr_q[$];
  done_t      done_q[$];
  logic [7:0] app_q[$];

  logic [7:0]  next_byte = 8'h00;
  logic [7:0]  exp_next  = 8'h00;
  logic [31:0] m_snd = '0;
  logic [15:0] m_seg = '0;
  int          err_cnt = 0;
  logic        hs_src = 1'b0;
  logic        prev_hv = 1'b0;
  logic        stall_en = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: event not expected or bound expired", nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: handshakes, header rise, header fall (post-done state), error pulses.
  always @(negedge clk) begin : monitor
    beat_t b;
    hdr_t  h;
    done_t d;
    hs_src = s_tvalid && s_tready;
    if (rst) begin
      prev_hv = 1'b0;
    end else begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else begin
          b = exp_q.pop_front();
          chk("beat_data", m_tdata, b.d);
          chk("beat_last", m_tlast, b.last);
          chk("beat_keep", m_tkeep, 1);
        end
      end
      if (err) err_cnt++;
      if (hdr_valid && !prev_hv) begin
        if (hdr_q.size() == 0) fail_now("unexpected_hdr");
        else begin
          h = hdr_q.pop_front();
          chk("hdr_seq", seq_number, h.seq);
          chk("hdr_ack", ack_number, h.ack);
          chk("hdr_ip_len", ip_len, h.ip_len);
          chk("hdr_no_data", no_data, h.nd);
          chk("hdr_flags", flags, h.flags);
          chk("hdr_window", win_out, h.win);
          chk("hdr_sport", sport_out, h.sp);
          chk("hdr_dport", dport_out, h.dp);
          chk("hdr_sip", sip_out, h.sip);
          chk("hdr_dip", dip_out, h.dip);
        end
      end
      if (!hdr_valid && prev_hv) begin
        if (done_q.size() == 0) fail_now("unexpected_done");
        else begin
          d = done_q.pop_front();
          chk("done_snd_nxt", snd_nxt, d.snd);
          chk("done_seg_count", seg_count, d.seg);
        end
      end
      prev_hv = hdr_valid;
    end
  end

  // Application source and downstream sink, updated just after each rising edge.
  initial begin
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hs_src && app_q.size() > 0) void'(app_q.pop_front());
      s_tvalid = (app_q.size() > 0) && (!stall_en || $urandom_range(0, 3) != 0);
      s_tdata  = (app_q.size() > 0) ? app_q[0] : 8'h00;
      m_tready = !stall_en || ($urandom_range(0, 2) != 0);
    end
  end

  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      app_q.push_back(next_byte);
      next_byte++;
    end
  endtask

  task automatic do_req(input logic [15:0] len, input logic [7:0] fl, input logic [31:0] ack,
                        input bit ld, input logic [31:0] ld_val);
    int          t;
    logic [15:0] l;
    hdr_t        h;
    done_t       d;
    t = 0;
    while (!req_ready && !seq_load && t < 100) begin
      tick(1);
      t++;
    end
    if (t >= 100) fail_now("req_ready_timeout");
    if (ld) m_snd = ld_val;
    l = (len > 16'd1460) ? 16'd1460 : len;
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back('{d: exp_next, last: (i == int'(l) - 1)});
      exp_next++;
    end
    h.seq = m_snd; h.ack = ack; h.ip_len = l + 16'd40; h.nd = (l == 16'd0); h.flags = fl;
    h.win = 16'h4000 ^ len; h.sp = 16'd8080 + len; h.dp = 16'd443;
    h.sip = 32'hC0A8_0001; h.dip = 32'h0A00_0000 | 32'(len);
    hdr_q.push_back(h);
    m_snd = m_snd + 32'(l) + 32'(fl[1]) + 32'(fl[0]);
    m_seg = m_seg + 16'd1;
    d.snd = m_snd; d.seg = m_seg;
    done_q.push_back(d);
    req_len = len; req_flags = fl; rcv_nxt = ack; window_size = h.win;
    source_port = h.sp; dest_port = h.dp; src_ip = h.sip; dst_ip = h.dip;
    if (ld) begin
      seq_load = 1'b1;
      seq_init = ld_val;
    end
    req_valid = 1'b1;
    if (ld) begin
      #1;
      chk("ready_low_on_load", req_ready, 0);
      tick(1);
      seq_load = 1'b0;
      chk("snd_after_load", snd_nxt, ld_val);
    end
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic finish_pkt;
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 20000) begin
      tick(1);
      t++;
    end
    if (t >= 20000) fail_now("payload_timeout");
    tick(2);
    packet_done = 1'b1;
    tick(1);
    packet_done = 1'b0;
    tick(1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int e0;
    int t;
    tick(2);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_snd_nxt", snd_nxt, 0);
    chk("rst_seg_count", seg_count, 0);
    chk("rst_err", err, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_seq_number", seq_number, 0);
    rst = 1'b0;
    tick(1);
    chk("idle_req_ready", req_ready, 1);

    // Basic 5-byte segment after loading the sequence number.
    seq_load = 1'b1; seq_init = 32'h1000_0000;
    tick(1);
    seq_load = 1'b0;
    m_snd = 32'h1000_0000;
    chk("snd_loaded", snd_nxt, 32'h1000_0000);
    push_bytes(5);
    do_req(16'd5, 8'h18, 32'h2222_0001, 1'b0, '0);
    finish_pkt();
    chk("t1_snd_nxt", snd_nxt, 32'h1000_0005);
    chk("t1_seg_count", seg_count, 16'd1);

    // Done while idle must not move SND.NXT.
    packet_done = 1'b1;
    tick(1);
    packet_done = 1'b0;
    tick(1);
    chk("idle_done_snd", snd_nxt, 32'h1000_0005);
    chk("idle_done_seg", seg_count, 16'd1);

    // Zero-length SYN wrapping SND.NXT.
    seq_load = 1'b1; seq_init = 32'hFFFF_FFFF;
    tick(1);
    seq_load = 1'b0;
    m_snd = 32'hFFFF_FFFF;
    do_req(16'd0, 8'h02, 32'h2222_0002, 1'b0, '0);
    finish_pkt();
    chk("t2_snd_wrap", snd_nxt, 32'h0000_0000);
    chk("t2_seg_count", seg_count, 16'd2);

    // Oversized request, clamped to MSS, with random stalls.
    stall_en = 1'b1;
    push_bytes(1460);
    e0 = err_cnt;
    do_req(16'd2000, 8'h10, 32'h2222_0003, 1'b0, '0);
    finish_pkt();
    chk("t3_err_pulses", err_cnt - e0, 1);
    chk("t3_snd_nxt", snd_nxt, 32'd1460);

    // One stream split across two segments; no clamp error expected.
    push_bytes(10);
    e0 = err_cnt;
    do_req(16'd4, 8'h18, 32'h2222_0004, 1'b0, '0);
    finish_pkt();
    do_req(16'd6, 8'h18, 32'h2222_0005, 1'b0, '0);
    finish_pkt();
    chk("t4_no_err", err_cnt - e0, 0);
    chk("t4_snd_nxt", snd_nxt, 32'd1470);
    chk("t4_app_drained", app_q.size(), 0);

    // Seq load and request in the same idle cycle.
    push_bytes(2);
    do_req(16'd2, 8'h18, 32'h2222_0006, 1'b1, 32'hABCD_0000);
    finish_pkt();
    chk("t5_snd_nxt", snd_nxt, 32'hABCD_0002);

    // Reset in the middle of a segment, then a fresh FIN segment.
    stall_en = 1'b0;
    push_bytes(8);
    do_req(16'd8, 8'h18, 32'h2222_0007, 1'b0, '0);
    t = 0;
    while (exp_q.size() > 5 && t < 200) begin
      tick(1);
      t++;
    end
    if (t >= 200) fail_now("t6_partial_timeout");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_hdr_valid", hdr_valid, 0);
    chk("t6_rst_m_tvalid", m_tvalid, 0);
    chk("t6_rst_s_tready", s_tready, 0);
    chk("t6_rst_snd_nxt", snd_nxt, 0);
    chk("t6_rst_seg_count", seg_count, 0);
    exp_q.delete();
    done_q.delete();
    app_q.delete();
    exp_next = next_byte;
    m_snd = '0;
    m_seg = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    push_bytes(3);
    do_req(16'd3, 8'h01, 32'h2222_0008, 1'b0, '0);
    finish_pkt();
    chk("t6_snd_nxt", snd_nxt, 32'd4);
    chk("t6_seg_count", seg_count, 16'd1);

    tick(2);
    chk("end_exp_q_empty", exp_q.size(), 0);
    chk("end_hdr_q_empty", hdr_q.size(), 0);
    chk("end_done_q_empty", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tcp_tx_ctrl.md
Name: tcp_tx_ctrl

Overview:
Transmit-side controller that sits directly upstream of tcp_packet_generator. It accepts per-segment send requests from the connection state machine and holds the complete header bundle (ports, seq/ack, flags, window, IPs, IP length) stable for the whole packet. It segments the application byte stream into payloads of the requested length and forces tlast on each segment's final byte. It owns the send sequence number (SND.NXT) and advances it when the generator reports packet done.

Parameters:
MSS, 1460, maximum payload bytes per segment; larger requests are clamped.
LEN_W, 16, width of the request length field.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_req_valid  in  1  send request
o_req_ready  out  1  high only in IDLE
i_req_len  in  LEN_W  payload byte count
i_req_flags  in  8  TCP flags (bit1 SYN, bit0 FIN)
i_rcv_nxt  in  32  ack number, sampled at request accept
i_window_size  in  16  sampled at accept
i_source_port / i_dest_port  in  16 each  sampled at accept
i_src_ip / i_dst_ip  in  32 each  sampled at accept
i_seq_load  in  1  load SND.NXT (honoured in IDLE only)
i_seq_init  in  32  value for i_seq_load
s_axis_app  axis_intf.SLAVE  8-bit data  application byte stream; tlast ignored
m_axis_data  axis_intf.MASTER  8-bit data  to generator payload input
o_hdr_valid  out  1  header bundle valid
o_no_data  out  1  latched length == 0
o_ip_len  out  16  40 + latched length
o_seq_number  out  32  SND.NXT at accept
o_ack_number / o_flags / o_window_size / o_source_port / o_dest_port / o_src_ip / o_dst_ip  out  latched copies
i_packet_done  in  1  single-cycle done from generator
o_snd_nxt  out  32  live SND.NXT
o_err  out  1  one-cycle pulse: length clamped
o_seg_count  out  16  segments completed, wraps

Behaviour:
- Reset, asynchronous: state IDLE, SND.NXT = 0, all latched fields = 0, o_hdr_valid = 0, o_seg_count = 0, o_err = 0, byte counter = 0, m_axis_data.tvalid = 0.
- States:
  - IDLE → SEND on i_req_valid & o_req_ready.
  - SEND → WAIT_DONE when the last payload byte handshakes on m_axis_data.
  - SEND → WAIT_DONE immediately, next cycle, when length = 0.
  - WAIT_DONE → IDLE on i_packet_done.
- Accept cycle:
  - Latch all header inputs, the length, and o_seq_number = SND.NXT.
  - If i_req_len > MSS, latch MSS and pulse o_err the next cycle.
- o_hdr_valid is registered: high in SEND and WAIT_DONE, low in IDLE. It falls the cycle after i_packet_done. Latched outputs hold stable while o_hdr_valid = 1.
- In IDLE, i_seq_load sets SND.NXT = i_seq_init. If i_req_valid arrives the same cycle, the load wins and the request waits (o_req_ready = 0 that cycle). i_seq_load is ignored outside IDLE.
- Data path in SEND:
  - Combinational pass-through: m_axis_data.tdata = s_axis_app.tdata, tvalid = s_axis_app.tvalid, s_axis_app.tready = m_axis_data.tready, tkeep = 1.
  - Byte counter increments on each handshake.
  - m_axis_data.tlast = 1 when counter == len−1.
  - Outside SEND, s_axis_app.tready = 0 and m_axis_data.tvalid = 0.
  - Bytes beyond len remain in the application stream for the next segment.
- i_packet_done:
  - In WAIT_DONE: SND.NXT += len + SYN + FIN, modulo 2^32 (wraps), and o_seg_count += 1.
  - In SEND (protocol violation): ignored.
  - In IDLE: ignored.
- Zero-latency request path: o_hdr_valid is high the cycle after accept. Payload forwarding starts in that same cycle, gated by downstream tready.
- Reset mid-packet: return to IDLE at once; the partial segment is abandoned and SND.NXT = 0.

Test Plan:
- Load seq 0x1000_0000; request len 5, flags 0x18; stream 5 bytes → o_ip_len = 45; tlast on byte 5; after done, o_snd_nxt = 0x1000_0005, o_seg_count = 1.
- Request len 0, flags 0x02 (SYN), seq 0xFFFF_FFFF → o_no_data = 1; no data beats; after done, o_snd_nxt = 0x0000_0000 (wrap).
- Request len 2000 → o_err pulses once; o_ip_len = 1500; tlast on byte 1460.
- App stream of 10 bytes; two requests of len 4 then 6 → segment 1 carries bytes 0–3, segment 2 carries bytes 4–9, each with tlast on its final byte; random tready/tvalid stalls cause no byte loss.
- i_seq_load and i_req_valid in the same IDLE cycle → load is applied, request is accepted the next cycle, and o_seq_number equals i_seq_init.
- Assert i_rst mid-SEND → outputs return to reset values immediately; a fresh request then completes normally.
